// File: rtl/btb_update_queue_pkg.sv
`default_nettype none
// ============================================================================
// btb_pkg -- shared widths and update-entry type for the BTB update queue
// Rev 1.0
// ============================================================================
package btb_pkg;

  localparam int XLEN          = 64;
  localparam int DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hist;
    logic [XLEN-1:0] target;
    logic            is_br;
    logic            is_jal;
  } btb_update_t;

endpackage
`default_nettype wire

// File: rtl/btb_update_queue_if.sv
`default_nettype none
// ============================================================================
// btb_update_queue_if -- resolution-side enqueue, BTB-side update, lookup/status
// Rev 1.0
// ============================================================================
interface btb_update_queue_if #(
  parameter int DEPTH = btb_pkg::DEPTH_DEFAULT,
  parameter int XLEN  = btb_pkg::XLEN
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_hist;
  logic [XLEN-1:0] enq_target;
  logic            enq_is_br;
  logic            enq_is_jal;

  logic            upd_valid;
  logic            upd_ready;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_hist;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_br;
  logic            upd_is_jal;

  logic            flush;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_hit;
  logic [XLEN-1:0] lookup_target;
  logic [CW-1:0]   count;
  logic [15:0]     drop_count;

  modport slave (
    input  enq_valid, enq_pc, enq_hist, enq_target, enq_is_br, enq_is_jal,
    input  upd_ready, flush, lookup_pc,
    output enq_ready, upd_valid, upd_pc, upd_hist, upd_target, upd_is_br, upd_is_jal,
    output lookup_hit, lookup_target, count, drop_count
  );

  modport master (
    output enq_valid, enq_pc, enq_hist, enq_target, enq_is_br, enq_is_jal,
    output upd_ready, flush, lookup_pc,
    input  enq_ready, upd_valid, upd_pc, upd_hist, upd_target, upd_is_br, upd_is_jal,
    input  lookup_hit, lookup_target, count, drop_count
  );

endinterface
`default_nettype wire

// File: rtl/btb_update_queue_match.sv
`default_nettype none
// ============================================================================
// btb_uq_match -- newest-first pc search over the occupied queue slots
// Rev 1.0
// ============================================================================
module btb_uq_match #(
  parameter  int DEPTH = 8,
  parameter  int XLEN  = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][XLEN-1:0] pc_tbl_i,
  input  logic [XLEN-1:0]            lookup_pc_i,
  input  logic [DEPTH-1:0]           occ_i,
  input  logic [PW-1:0]              head_i,
  output logic                       hit_o,
  output logic [PW-1:0]              idx_o
);

  logic [PW-1:0] slot;

  // Walk from oldest (head) to newest so the last match seen is the newest one.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    slot  = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PW'(k);
      if (occ_i[slot] && (pc_tbl_i[slot] == lookup_pc_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btb_update_queue.sv
`default_nettype none
// ============================================================================
// btb_update_queue -- pending BTB update FIFO with newest-entry coalescing
// Rev 1.0
// ============================================================================
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,   // power of two, >= 2
  parameter int XLEN  = btb_pkg::XLEN
) (
  input  logic              clock,
  input  logic              reset,
  btb_update_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;

  logic [DEPTH-1:0][XLEN-1:0] pc_q;
  logic [DEPTH-1:0][XLEN-1:0] hist_q;
  logic [DEPTH-1:0][XLEN-1:0] target_q;
  logic [DEPTH-1:0]           br_q;
  logic [DEPTH-1:0]           jal_q;

  logic [PW-1:0]    newest;
  logic [DEPTH-1:0] occ;
  logic             deq;
  logic             coalesce_ok;
  logic             enq_ready;
  logic             enq_fire;
  logic             push;
  logic             merge;
  logic             match_hit;
  logic [PW-1:0]    match_idx;

  assign newest = tail_q - PW'(1);
  assign deq    = (count_q != '0) && bus.upd_ready;

  // A lone entry leaving this cycle cannot absorb the offer; it must go in fresh.
  assign coalesce_ok = (count_q != '0)
                    && (pc_q[newest] == bus.enq_pc)
                    && !((count_q == CW'(1)) && deq);

  assign enq_ready = !reset && !bus.flush
                  && ((count_q < CW'(DEPTH)) || coalesce_ok);
  assign enq_fire  = bus.enq_valid && enq_ready;
  assign push      = enq_fire && !coalesce_ok;
  assign merge     = enq_fire && coalesce_ok;

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(deq);
    drop_d  = drop_q;
    if (bus.enq_valid && !enq_ready && !bus.flush && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail_q]     <= bus.enq_pc;
      hist_q[tail_q]   <= bus.enq_hist;
      target_q[tail_q] <= bus.enq_target;
      br_q[tail_q]     <= bus.enq_is_br;
      jal_q[tail_q]    <= bus.enq_is_jal;
    end else if (merge) begin
      hist_q[newest]   <= bus.enq_hist;
      target_q[newest] <= bus.enq_target;
      br_q[newest]     <= bus.enq_is_br;
      jal_q[newest]    <= bus.enq_is_jal;
    end
  end

  // Occupied slots are the count_q entries starting at head.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] age;
    assign age    = PW'(i) - head_q;
    assign occ[i] = CW'(age) < count_q;
  end

  btb_uq_match #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_match (
    .pc_tbl_i    (pc_q),
    .lookup_pc_i (bus.lookup_pc),
    .occ_i       (occ),
    .head_i      (head_q),
    .hit_o       (match_hit),
    .idx_o       (match_idx)
  );

  assign bus.enq_ready     = enq_ready;
  assign bus.upd_valid     = !reset && (count_q != '0);
  assign bus.upd_pc        = pc_q[head_q];
  assign bus.upd_hist      = hist_q[head_q];
  assign bus.upd_target    = target_q[head_q];
  assign bus.upd_is_br     = br_q[head_q];
  assign bus.upd_is_jal    = jal_q[head_q];
  assign bus.lookup_hit    = !reset && match_hit;
  assign bus.lookup_target = bus.lookup_hit ? target_q[match_idx] : '0;
  assign bus.count         = reset ? '0 : count_q;
  assign bus.drop_count    = reset ? '0 : drop_q;

endmodule
`default_nettype wire

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter XLEN, default 64, width of pc/hist/target fields.
REQ-003 clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 enq_valid  in  1  branch-resolution update offered.
REQ-005 enq_ready  out  1  update accepted this cycle when high with enq_valid.
REQ-006 enq_pc/enq_hist/enq_target  in  XLEN each  resolved branch pc, global history, target.
REQ-007 enq_is_br/enq_is_jal  in  1 each  branch-kind flags.
REQ-008 upd_valid  out  1  head entry presented to the BTB update port.
REQ-009 upd_ready  in  1  BTB consumes head this cycle.
REQ-010 upd_pc/upd_hist/upd_target  out  XLEN each; upd_is_br/upd_is_jal  out  1 each  head entry fields.
REQ-011 flush  in  1  discard all pending updates.
REQ-012 lookup_pc  in  XLEN  frontend fetch pc probed against pending entries.
REQ-013 lookup_hit  out  1; lookup_target  out  XLEN  pending-entry match and its target.
REQ-014 count  out  $clog2(DEPTH+1)  occupied entries; drop_count  out  16  refused offers, saturating.

Function
REQ-015 Storage SHALL be a circular FIFO, head/tail pointers wrapping modulo DEPTH.
REQ-016 upd_valid SHALL equal (count != 0); upd_* SHALL be driven directly from head storage, no output register.
REQ-017 Dequeue (upd_valid && upd_ready) SHALL advance head and decrement count at the next edge.
REQ-018 Enqueue-to-upd_valid latency SHALL be exactly 1 cycle from empty; no same-cycle bypass.
REQ-019 coalesce_ok SHALL be: count >= 1 && newest entry pc == enq_pc && !(count == 1 && dequeue this cycle).
REQ-020 enq_ready SHALL be !flush && (count < DEPTH || coalesce_ok); combinational, no dependence on enq_valid.
REQ-021 Accepted offer with coalesce_ok SHALL overwrite newest entry's hist/target/is_br/is_jal; count unchanged.
REQ-022 Accepted offer without coalesce_ok SHALL write at tail, advance tail, increment count.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; when full, enq_ready is low unless coalesce_ok, regardless of upd_ready.
REQ-024 flush SHALL empty the queue at the next edge, priority over enqueue and dequeue; upd_valid stays as-is in the flush cycle.
REQ-025 drop_count SHALL increment when enq_valid && !enq_ready && !flush, saturating at 0xFFFF.
REQ-026 lookup SHALL be combinational over occupied entries; newest matching entry wins; lookup_target = 0 when no hit.

Reset
REQ-027 Reset SHALL zero head, tail, count and drop_count and invalidate all entries; entry data need not be cleared.
REQ-028 During reset and the cycle after: upd_valid 0, lookup_hit 0, lookup_target 0, count 0, drop_count 0; enq_ready 0 during reset, 1 after.
REQ-029 Reset mid-operation SHALL discard pending entries without emitting them.

Structure
REQ-030 Shared package btb_pkg SHALL hold XLEN, default DEPTH and typedef btb_update_t {pc, hist, target, is_br, is_jal}.
REQ-031 Sub-module btb_uq_match SHALL implement the newest-priority pc search (occupancy mask, head pointer in; hit, index out).
REQ-032 The block SHALL be synthesizable; no DPI or simulation-only constructs.

Verification
REQ-033 Empty queue, enqueue pc=0x1000 target=0x2000, upd_ready=1 -> upd_valid high next cycle with upd_target=0x2000; count 1 then 0.
REQ-034 upd_ready=0, enqueue 8 distinct pcs -> count 8, enq_ready 0; 9th distinct offer -> drop_count 1; then upd_ready=1 drains 8 in order.
REQ-035 Enqueue pc=0x1000 target=0x2000, then pc=0x1000 target=0x3000 while upd_ready=0 -> count 1, upd_target=0x3000.
REQ-036 Full queue, newest pc=0x40, offer pc=0x40 -> enq_ready 1, count stays 8; offer pc=0x44 same cycle as dequeue -> refused.
REQ-037 Entries pc=0x80 tgt=0x100 and pc=0x80 tgt=0x200 non-adjacent, lookup_pc=0x80 -> lookup_hit 1, lookup_target 0x200.
REQ-038 count 5, flush with enq_valid high -> count 0, upd_valid 0 next cycle, drop_count unchanged; reset mid-drain -> no further upd_valid.
